ising_instr_sequencer: RTL

- Executes a stored instruction program that moves operands between the a, b and c variable FIFOs feeding the MAC/NL datapath.
- Software loads instruction words through the config-register path (instr write port), then fires run_trig.
- The sequencer fetches each word, waits until every FIFO it touches is ready, then issues single-cycle push/pop strobes.
- Exposes instruction count and execution state for the instr_count_reg and ex_state_reg readbacks.

---
 rtl/ising_instr_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ising_instr_sequencer.sv
// Instruction sequencer: replays a small stored program of FIFO push/pop words,
// issuing each word's strobes once every FIFO it touches is ready.
module ising_instr_sequencer #(
  parameter int NUM_BITS = 8,
  parameter int INSTR_AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_wr_en,
  input  logic [15:0]         instr_wr_data,
  input  logic                prog_clr,
  input  logic                run_trig,
  input  logic                halt,
  input  logic                a_full,
  input  logic                c_full,
  input  logic                a_empty,
  input  logic                b_empty,
  input  logic                c_empty,
  output logic                a_push,
  output logic                c_push,
  output logic [NUM_BITS-1:0] a_push_data,
  output logic [NUM_BITS-1:0] c_push_data,
  output logic                a_pop,
  output logic                b_pop,
  output logic                c_pop,
  output logic [15:0]         instr_count,
  output logic [INSTR_AW:0]   prog_len,
  output logic [2:0]          ex_state,
  output logic                busy,
  output logic                wr_err
);

  localparam int DEPTH = 1 << INSTR_AW;
  localparam logic [INSTR_AW:0] PROG_MAX = (INSTR_AW + 1)'(DEPTH);
  localparam logic [INSTR_AW:0] LEN_ONE  = (INSTR_AW + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [INSTR_AW-1:0] pc_reg, pc_next;
  logic [15:0]         instr_count_reg, instr_count_next;
  logic [INSTR_AW:0]   prog_len_reg, prog_len_next;
  logic                wr_err_reg, wr_err_next;

  logic [15:0]         instr_mem [DEPTH];
  logic [15:0]         instr_reg;

  logic                wr_accept;
  logic                prog_full;
  logic                last_instr;
  logic [2:0]          pop_req, pop_ok, fifo_empty;
  logic [1:0]          push_req, push_ok, fifo_full;
  logic                ready;
  logic                fire;
  logic [NUM_BITS-1:0] operand;
  logic                unused_bits;

  assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE);
  assign prog_full = (prog_len_reg == PROG_MAX);
  assign wr_accept = instr_wr_en && !busy && !prog_full && !prog_clr;

  // Program store: writes only land while idle, so they never race the fetch read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      instr_mem[prog_len_reg[INSTR_AW-1:0]] <= instr_wr_data;
    end
    if (state_reg == ST_FETCH) begin
      instr_reg <= instr_mem[pc_reg];
    end
  end

  // Instruction decode: bits [2:0] pop a/b/c, bits [5:4] push a/c.
  assign fifo_empty = {c_empty, b_empty, a_empty};
  assign fifo_full  = {c_full, a_full};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pop
      assign pop_req[gi] = instr_reg[gi];
      assign pop_ok[gi]  = !pop_req[gi] || !fifo_empty[gi];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_push
      assign push_req[gi] = instr_reg[4 + gi];
      assign push_ok[gi]  = !push_req[gi] || !fifo_full[gi];
    end
  endgenerate

  assign ready       = (&pop_ok) && (&push_ok);
  assign fire        = (state_reg == ST_ISSUE) && ready && !halt;
  assign operand     = NUM_BITS'(instr_reg[15:8]);
  assign unused_bits = ^{instr_reg[7:6], instr_reg[3]};

  assign a_pop       = fire && pop_req[0];
  assign b_pop       = fire && pop_req[1];
  assign c_pop       = fire && pop_req[2];
  assign a_push      = fire && push_req[0];
  assign c_push      = fire && push_req[1];
  assign a_push_data = a_push ? operand : '0;
  assign c_push_data = c_push ? operand : '0;

  assign last_instr  = (({1'b0, pc_reg} + LEN_ONE) == prog_len_reg);

  // Program length and write-error bookkeeping.
  always_comb begin
    prog_len_next = prog_len_reg;
    wr_err_next   = wr_err_reg;
    if (!busy && prog_clr) begin
      prog_len_next = '0;
      wr_err_next   = 1'b0;
    end else if (instr_wr_en) begin
      if (busy || prog_full) begin
        wr_err_next = 1'b1;
      end else begin
        prog_len_next = prog_len_reg + LEN_ONE;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_count_next = instr_count_reg;
    if (halt) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (run_trig) begin
            if (prog_len_reg == '0) begin
              state_next = ST_DONE;
            end else begin
              pc_next          = '0;
              instr_count_next = '0;
              state_next       = ST_FETCH;
            end
          end
        end
        ST_FETCH: state_next = ST_ISSUE;
        ST_ISSUE: begin
          if (ready) begin
            if (instr_count_reg != 16'hFFFF) begin
              instr_count_next = instr_count_reg + 16'd1;
            end
            if (last_instr) begin
              state_next = ST_DONE;
            end else begin
              pc_next    = pc_reg + INSTR_AW'(1);
              state_next = ST_FETCH;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= '0;
      instr_count_reg <= '0;
      prog_len_reg    <= '0;
      wr_err_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_count_reg <= instr_count_next;
      prog_len_reg    <= prog_len_next;
      wr_err_reg      <= wr_err_next;
    end
  end

  assign instr_count = instr_count_reg;
  assign prog_len    = prog_len_reg;
  assign ex_state    = state_reg;
  assign wr_err      = wr_err_reg;

endmodule
